// File: rtl/ctrl_pkg.sv
// Shared definitions for the simple-processor control unit: opcodes, step
// encoding and instruction field positions.
package ctrl_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    // Instruction format III XXX YYY
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } stepT;

    function automatic logic isArith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/control_unit_dec3to8.sv
// Binary-to-one-hot decoder with enable; drives the register write enables.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for the 16-bit simple processor datapath (steps T0..T3).
// Optional macro CTRL_MVNZ_EN adds the conditional move mvnz (opcode 100).
module control_unit
    import ctrl_pkg::*;
#(
    parameter int IR_W = 9,
    parameter int NREG = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [15:0]     DIN,
    input  logic            GNZ,
    output logic [NREG-1:0] selectR,
    output logic            selectG,
    output logic            selectDin,
    output logic [NREG-1:0] Rin,
    output logic            Ain,
    output logic            Gin,
    output logic            AddSub,
    output logic            IRin,
    output logic            Done
);

    stepT            step;
    stepT            nextStep;
    logic [IR_W-1:0] ir;
    logic [2:0]      opcode;
    logic [2:0]      rx;
    logic [2:0]      ry;
    logic [2:0]      busIdx;
    logic            rinEn;
    logic            fetch;

    assign opcode = ir[OP_MSB:OP_LSB];
    assign rx     = ir[RX_MSB:RX_LSB];
    assign ry     = ir[RY_MSB:RY_LSB];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step <= T0;
            ir   <= '0;
        end else begin
            step <= nextStep;
            if (step == T0 && Run) begin
                ir <= DIN[IR_W-1:0];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a signal unassigned (no latches).
    always_comb begin
        nextStep  = step;
        busIdx    = 3'd0;
        rinEn     = 1'b0;
        fetch     = 1'b0;
        selectG   = 1'b0;
        selectDin = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;

        unique case (step)
            T0: begin
                fetch = Run;
                if (Run) begin
                    nextStep = T1;
                end
            end
            T1: begin
                nextStep = T0;
                case (opcode)
                    OP_MV: begin
                        busIdx = ry;
                        rinEn  = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_MVI: begin
                        selectDin = 1'b1;
                        rinEn     = 1'b1;
                        Done      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        busIdx   = rx;
                        Ain      = 1'b1;
                        nextStep = T2;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        busIdx = ry;
                        rinEn  = GNZ;
                        Done   = 1'b1;
                    end
`endif
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                busIdx   = ry;
                Gin      = 1'b1;
                AddSub   = opcode[0];
                nextStep = T3;
            end
            T3: begin
                // Only add/sub reach T3; the write-back always targets X.
                selectG  = isArith(opcode);
                rinEn    = 1'b1;
                Done     = 1'b1;
                nextStep = T0;
            end
        endcase
    end

    // Reset forces T0, where Run would otherwise leak straight onto IRin.
    assign IRin    = fetch & Resetn;
    assign selectR = {{(NREG-3){1'b0}}, busIdx};

    dec3to8 uRinDec (
        .w  (rx),
        .en (rinEn),
        .y  (Rin)
    );

`ifdef CTRL_MVNZ_EN
    logic unusedDinBits;
    assign unusedDinBits = ^DIN[15:IR_W];
`else
    logic unusedDinBits;
    assign unusedDinBits = ^{DIN[15:IR_W], GNZ};
`endif

endmodule
